fetch_pc_unit: RTL and testbench

Instruction-fetch front end: owns the architectural PC, issues word fetches to instruction memory, and buffers returned instructions toward decode. Sits at the opposite end of the branch-resolution path. The branch unit produces the next-PC/redirect, and this block consumes it, retargets the PC and discards every wrong-path fetch. Up to two fetches are in flight. A per-request epoch tag drops stale responses after a redirect.

---
 rtl/fetch_pc_unit_pkg.sv | 36 +++
 rtl/fetch_fifo.sv | 46 ++++
 rtl/fetch_pc_unit.sv | 94 +++++++++
 tb/tb_fetch_pc_unit.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_unit_pkg.sv
// Shared constants, FSM encodings and record layouts for the fetch front end.
// Also holds the small helpers used by both the PC logic and the credit check.
package fetch_pc_unit_pkg;

  localparam logic [31:0] NOP          = 32'h0000_0013;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  localparam logic [0:0] ST_BOOT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // In-flight request tag: where it was fetched from and under which epoch.
  typedef struct packed {
    logic [31:0] pc;
    logic        epoch;
  } tag_t;

  // Decoded-side buffer slot.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } slot_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  // Total of outstanding fetches and buffered instructions must stay below 2
  // so a returning response always finds room in the output buffer.
  function automatic logic credit_ok(input logic [1:0] inflight,
                                     input logic [1:0] buffered);
    logic [2:0] total;
    total = {1'b0, inflight} + {1'b0, buffered};
    return total < 3'd2;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry synchronous FIFO with flush and occupancy count.
// Pointers/count are reset; the storage array is not.
module fetch_fifo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: owns the PC, issues word fetches with epoch tags,
// drops wrong-path responses after a redirect and buffers the rest for decode.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  logic [0:0]  state;
  logic [31:0] pc;
  logic        epoch;

  logic        req_fire;
  logic        rsp_take;
  logic        rsp_keep;
  logic        out_fire;
  tag_t        tag_in;
  tag_t        tag_head;
  slot_t       slot_in;
  slot_t       slot_head;
  logic [1:0]  tag_count;
  logic [1:0]  buf_count;

  // Only registered occupancies feed the request valid.
  assign imem_req_valid = (state == ST_RUN) && credit_ok(tag_count, buf_count);
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response in a redirect cycle still carries the pre-redirect epoch, so it
  // is dropped even though the epoch register has not toggled yet.
  assign rsp_take = imem_rsp_valid && (tag_count != 2'd0);
  assign rsp_keep = rsp_take && (tag_head.epoch == epoch) && !redirect_valid;

  assign out_valid = (buf_count != 2'd0);
  assign out_fire  = out_valid && out_ready;
  assign out_instr = out_valid ? slot_head.instr : NOP;
  assign out_pc    = out_valid ? slot_head.pc : 32'h0000_0000;

  assign tag_in  = '{pc: pc, epoch: epoch};
  assign slot_in = '{instr: imem_rsp_data, pc: tag_head.pc};

  fetch_fifo #(.WIDTH($bits(tag_t))) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .push      (req_fire),
    .push_data (tag_in),
    .pop       (rsp_take),
    .head      (tag_head),
    .count     (tag_count)
  );

  fetch_fifo #(.WIDTH($bits(slot_t))) u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (rsp_keep),
    .push_data (slot_in),
    .pop       (out_fire),
    .head      (slot_head),
    .count     (buf_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_BOOT;
      pc    <= RESET_PC;
      epoch <= 1'b0;
    end else begin
      state <= ST_RUN;
      if (redirect_valid) begin
        pc    <= align_word(redirect_pc);
        epoch <= ~epoch;
      end else if (req_fire) begin
        pc <= pc + 32'd4;
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: in-order memory model with random
// latency plus a queue-based reference of the fetch/deliver rules.
module tb_fetch_pc_unit;

  localparam logic [31:0] NOP_I = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  always #5 clk = ~clk;

  fetch_pc_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; int gen; } mtag_t;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  mreq_t       memq[$];
  mtag_t       tagq[$];
  logic [31:0] outq[$];
  logic [31:0] m_pc;
  int          m_gen;
  bit          m_run;
  bit          stray;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          exp_rv, exp_ov;
  logic [31:0] exp_addr, exp_opc, exp_ins;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_gen = 0; m_run = 1'b0;
    tagq.delete(); outq.delete(); memq.delete();
    stray = 1'b0;
  endtask

  task automatic restart();
    rst = 1'b1;
    imem_req_ready = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    model_reset();
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive one cycle's inputs and compute what the outputs must be right now.
  task automatic drive(input bit rdy, input bit ordy);
    imem_req_ready = rdy; out_ready = ordy;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    if (stray) begin
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    end else if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(memq[0].addr);
    end
    exp_rv   = m_run && (tagq.size() + outq.size() < 2);
    exp_addr = m_pc;
    exp_ov   = outq.size() > 0;
    exp_opc  = exp_ov ? outq[0] : 32'h0;
    exp_ins  = exp_ov ? mem_word(outq[0]) : NOP_I;
  endtask

  // Apply the fetch rules for the current cycle, then cross the clock edge.
  task automatic advance();
    bit    mfire, ofire;
    mtag_t t;
    int    lat;
    lat   = int'($urandom_range(lat_max, lat_min));
    mfire = exp_rv && imem_req_ready;
    ofire = exp_ov && out_ready;
    if (imem_req_valid && imem_req_ready) memq.push_back('{imem_req_addr, cyc + lat});
    if (imem_rsp_valid && !stray) void'(memq.pop_front());
    stray = 1'b0;
    if (ofire) void'(outq.pop_front());
    if (imem_rsp_valid && tagq.size() > 0) begin
      t = tagq.pop_front();
      if ((t.gen % 2) == (m_gen % 2) && !redirect_valid) outq.push_back(t.pc);
    end
    if (mfire) begin
      tagq.push_back('{m_pc, m_gen});
      m_pc = m_pc + 32'd4;
    end
    if (redirect_valid) begin
      m_pc = redirect_pc & 32'hFFFF_FFFC;
      m_gen++;
      outq.delete();
    end
    m_run = 1'b1;
    @(posedge clk); cyc++; @(negedge clk);
  endtask

  task automatic test_reset();
    restart();
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid got %b want 0", imem_req_valid); end
    n_cmp++; if (imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL reset_req_addr got %h want 0", imem_req_addr); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_instr !== NOP_I) begin n_fail++; $display("FAIL reset_out_instr got %h want %h", out_instr, NOP_I); end
    n_cmp++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_out_pc got %h want 0", out_pc); end
    rst = 1'b0;
    drive(1'b1, 1'b1);
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL boot_idle got req_valid=%b want 0", imem_req_valid); end
    advance();
    drive(1'b1, 1'b1);
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL first_request got valid=%b addr=%h want 1/00000000", imem_req_valid, imem_req_addr); end
    advance();
  endtask

  task automatic test_stream();
    logic [31:0] reqs[$];
    int          req_cyc[$];
    logic [31:0] dlv[$];
    int          first_out = -1;
    bit          ok = 1'b1;
    restart(); lat_min = 1; lat_max = 1;
    for (int i = 0; i < 24; i++) begin
      drive(1'b1, 1'b1);
      n_cmp++;
      if ({imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr} !== {exp_rv, exp_addr, exp_ov, exp_opc, exp_ins}) begin
        n_fail++; $display("FAIL stream cyc=%0d got rv=%b a=%h ov=%b pc=%h i=%h want rv=%b a=%h ov=%b pc=%h i=%h", i, imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr, exp_rv, exp_addr, exp_ov, exp_opc, exp_ins);
      end
      if (imem_req_valid && imem_req_ready) begin reqs.push_back(imem_req_addr); req_cyc.push_back(i); end
      if (out_valid && first_out < 0) first_out = i;
      if (out_valid && out_ready) dlv.push_back(out_pc);
      advance();
    end
    n_cmp++;
    if (reqs.size() < 2 || reqs[0] !== 32'h0 || reqs[1] !== 32'h4 || req_cyc[0] != 1 || req_cyc[1] != 2) begin
      n_fail++; $display("FAIL stream_first_requests got %0d requests, want 0x0 at cycle 1 and 0x4 at cycle 2", reqs.size());
    end
    n_cmp++; if (first_out != 3) begin n_fail++; $display("FAIL stream_first_out_cycle got %0d want 3", first_out); end
    foreach (dlv[k]) if (dlv[k] !== 32'(4 * k)) ok = 1'b0;
    n_cmp++; if (!ok || dlv.size() < 8) begin n_fail++; $display("FAIL stream_order got %0d delivered in_order=%b want >=8 in order", dlv.size(), ok); end
  endtask

  task automatic test_stall();
    int          fires = 0;
    logic [31:0] dlv[$];
    bit          ok = 1'b1;
    restart(); lat_min = 1; lat_max = 1;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b0);
      n_cmp++;
      if ({imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr} !== {exp_rv, exp_addr, exp_ov, exp_opc, exp_ins}) begin
        n_fail++; $display("FAIL stall cyc=%0d got rv=%b a=%h ov=%b pc=%h want rv=%b a=%h ov=%b pc=%h", i, imem_req_valid, imem_req_addr, out_valid, out_pc, exp_rv, exp_addr, exp_ov, exp_opc);
      end
      if (imem_req_valid && imem_req_ready) fires++;
      advance();
    end
    n_cmp++; if (fires != 2 || imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL stall_credit got fires=%0d req_valid=%b want 2/0", fires, imem_req_valid); end
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1);
      n_cmp++;
      if ({imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr} !== {exp_rv, exp_addr, exp_ov, exp_opc, exp_ins}) begin
        n_fail++; $display("FAIL stall_release cyc=%0d got rv=%b a=%h ov=%b pc=%h want rv=%b a=%h ov=%b pc=%h", i, imem_req_valid, imem_req_addr, out_valid, out_pc, exp_rv, exp_addr, exp_ov, exp_opc);
      end
      if (out_valid && out_ready) dlv.push_back(out_pc);
      advance();
    end
    foreach (dlv[k]) if (dlv[k] !== 32'(4 * k)) ok = 1'b0;
    n_cmp++; if (!ok || dlv.size() < 6) begin n_fail++; $display("FAIL stall_order got %0d delivered in_order=%b want >=6 in order", dlv.size(), ok); end
  endtask

  task automatic test_redirect_inflight();
    bit          done = 1'b0;
    int          rcyc = -1;
    logic [31:0] first_pc = 32'hFFFF_FFFF;
    bit          seen = 1'b0;
    restart(); lat_min = 3; lat_max = 3;
    for (int i = 0; i < 30; i++) begin
      drive(1'b1, 1'b1);
      if (!done && tagq.size() == 2) begin redirect_valid = 1'b1; redirect_pc = 32'h103; done = 1'b1; rcyc = i; end
      n_cmp++;
      if ({imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr} !== {exp_rv, exp_addr, exp_ov, exp_opc, exp_ins}) begin
        n_fail++; $display("FAIL redirect cyc=%0d got rv=%b a=%h ov=%b pc=%h want rv=%b a=%h ov=%b pc=%h", i, imem_req_valid, imem_req_addr, out_valid, out_pc, exp_rv, exp_addr, exp_ov, exp_opc);
      end
      if (done && i == rcyc + 1) begin
        n_cmp++; if (imem_req_addr !== 32'h100) begin n_fail++; $display("FAIL redirect_target got %h want 00000100", imem_req_addr); end
      end
      if (done && i > rcyc && out_valid && !seen) begin first_pc = out_pc; seen = 1'b1; end
      advance();
    end
    if (!done) begin n_cmp++; n_fail++; $display("FAIL redirect_setup got no cycle with 2 in flight want one"); end
    n_cmp++; if (first_pc !== 32'h100) begin n_fail++; $display("FAIL redirect_first_out got %h want 00000100", first_pc); end
  endtask

  task automatic test_collide();
    bit          done = 1'b0;
    int          rcyc = -1;
    logic [31:0] fire_pc = 32'h0, rsp_pc = 32'h0;
    logic [31:0] dlv[$];
    restart(); lat_min = 1; lat_max = 1;
    for (int i = 0; i < 24; i++) begin
      drive(1'b1, 1'b1);
      if (!done && exp_rv && imem_rsp_valid && tagq.size() > 0) begin
        fire_pc = m_pc; rsp_pc = tagq[0].pc;
        redirect_valid = 1'b1; redirect_pc = 32'h400; done = 1'b1; rcyc = i;
      end
      n_cmp++;
      if ({imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr} !== {exp_rv, exp_addr, exp_ov, exp_opc, exp_ins}) begin
        n_fail++; $display("FAIL collide cyc=%0d got rv=%b a=%h ov=%b pc=%h want rv=%b a=%h ov=%b pc=%h", i, imem_req_valid, imem_req_addr, out_valid, out_pc, exp_rv, exp_addr, exp_ov, exp_opc);
      end
      if (done && i == rcyc + 1) begin
        n_cmp++; if (imem_req_addr !== 32'h400) begin n_fail++; $display("FAIL collide_target got %h want 00000400", imem_req_addr); end
      end
      if (done && i > rcyc && out_valid && out_ready) dlv.push_back(out_pc);
      advance();
    end
    if (!done) begin n_cmp++; n_fail++; $display("FAIL collide_setup got no fire+response cycle want one"); end
    n_cmp++;
    if (dlv.size() == 0 || dlv[0] !== 32'h400 || (fire_pc inside {dlv}) || (rsp_pc inside {dlv})) begin
      n_fail++; $display("FAIL collide_drop got %0d delivered first=%h want first 00000400 without %h or %h", dlv.size(), (dlv.size() > 0) ? dlv[0] : 32'h0, fire_pc, rsp_pc);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] dlv[$];
    bit          bad = 1'b0;
    restart(); lat_min = 2; lat_max = 2;
    for (int i = 0; i < 40; i++) begin
      drive(!(i >= 6 && i <= 10), 1'b1);
      if (i == 10) begin redirect_valid = 1'b1; redirect_pc = 32'h200; end
      if (i == 11) begin redirect_valid = 1'b1; redirect_pc = 32'h300; end
      n_cmp++;
      if ({imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr} !== {exp_rv, exp_addr, exp_ov, exp_opc, exp_ins}) begin
        n_fail++; $display("FAIL b2b cyc=%0d got rv=%b a=%h ov=%b pc=%h want rv=%b a=%h ov=%b pc=%h", i, imem_req_valid, imem_req_addr, out_valid, out_pc, exp_rv, exp_addr, exp_ov, exp_opc);
      end
      if (i == 12) begin
        n_cmp++; if (imem_req_addr !== 32'h300) begin n_fail++; $display("FAIL b2b_target got %h want 00000300", imem_req_addr); end
      end
      if (i >= 11 && out_valid && out_ready) dlv.push_back(out_pc);
      advance();
    end
    foreach (dlv[k]) if (dlv[k] >= 32'h200 && dlv[k] < 32'h300) bad = 1'b1;
    n_cmp++;
    if (bad || dlv.size() == 0 || dlv[0] !== 32'h300) begin
      n_fail++; $display("FAIL b2b_stream got first=%h stale_seen=%b want first 00000300 no 0x2xx", (dlv.size() > 0) ? dlv[0] : 32'h0, bad);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] reqs[$];
    logic [31:0] dlv[$];
    restart(); lat_min = 1; lat_max = 1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1);
      if (i == 4) begin redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8; end
      n_cmp++;
      if ({imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr} !== {exp_rv, exp_addr, exp_ov, exp_opc, exp_ins}) begin
        n_fail++; $display("FAIL wrap cyc=%0d got rv=%b a=%h ov=%b pc=%h want rv=%b a=%h ov=%b pc=%h", i, imem_req_valid, imem_req_addr, out_valid, out_pc, exp_rv, exp_addr, exp_ov, exp_opc);
      end
      if (i > 4 && imem_req_valid && imem_req_ready) reqs.push_back(imem_req_addr);
      if (i > 4 && out_valid && out_ready) dlv.push_back(out_pc);
      advance();
    end
    n_cmp++;
    if (reqs.size() < 3 || reqs[0] !== 32'hFFFF_FFF8 || reqs[1] !== 32'hFFFF_FFFC || reqs[2] !== 32'h0) begin
      n_fail++; $display("FAIL wrap_requests got %0d requests first=%h want FFFFFFF8,FFFFFFFC,00000000", reqs.size(), (reqs.size() > 0) ? reqs[0] : 32'h0);
    end
    n_cmp++;
    if (dlv.size() < 3 || dlv[0] !== 32'hFFFF_FFF8 || dlv[1] !== 32'hFFFF_FFFC || dlv[2] !== 32'h0) begin
      n_fail++; $display("FAIL wrap_delivery got %0d delivered first=%h want FFFFFFF8,FFFFFFFC,00000000", dlv.size(), (dlv.size() > 0) ? dlv[0] : 32'h0);
    end
  endtask

  task automatic test_random();
    int ndlv = 0;
    restart(); lat_min = 1; lat_max = 3;
    for (int i = 0; i < 800; i++) begin
      drive(($urandom % 4) != 0, ($urandom % 3) != 0);
      if (($urandom % 16) == 0) begin redirect_valid = 1'b1; redirect_pc = $urandom; end
      n_cmp++;
      if ({imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr} !== {exp_rv, exp_addr, exp_ov, exp_opc, exp_ins}) begin
        n_fail++; $display("FAIL random cyc=%0d got rv=%b a=%h ov=%b pc=%h i=%h want rv=%b a=%h ov=%b pc=%h i=%h", i, imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr, exp_rv, exp_addr, exp_ov, exp_opc, exp_ins);
      end
      if (out_valid && out_ready) ndlv++;
      advance();
    end
    n_cmp++; if (ndlv < 50) begin n_fail++; $display("FAIL random_progress got %0d delivered want >=50", ndlv); end
  endtask

  task automatic test_reset_mid();
    bit          done = 1'b0;
    logic [31:0] first_pc = 32'hFFFF_FFFF;
    bit          seen = 1'b0;
    restart(); lat_min = 1; lat_max = 1;
    for (int i = 0; i < 40 && !done; i++) begin
      drive(1'b1, 1'b1);
      if (i > 5 && exp_ov && tagq.size() > 0) begin
        rst = 1'b1; #1;
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_req_valid got %b want 0", imem_req_valid); end
        n_cmp++; if (imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL midrst_req_addr got %h want 0", imem_req_addr); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
        n_cmp++; if (out_instr !== NOP_I || out_pc !== 32'h0) begin n_fail++; $display("FAIL midrst_out got instr=%h pc=%h want %h/0", out_instr, out_pc, NOP_I); end
        done = 1'b1;
      end else begin
        advance();
      end
    end
    if (!done) begin n_cmp++; n_fail++; $display("FAIL midrst_setup got no busy cycle want one"); rst = 1'b1; end
    model_reset();
    @(posedge clk); @(negedge clk);
    rst = 1'b0; stray = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b1);
      n_cmp++;
      if ({imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr} !== {exp_rv, exp_addr, exp_ov, exp_opc, exp_ins}) begin
        n_fail++; $display("FAIL midrst_resume cyc=%0d got rv=%b a=%h ov=%b pc=%h want rv=%b a=%h ov=%b pc=%h", i, imem_req_valid, imem_req_addr, out_valid, out_pc, exp_rv, exp_addr, exp_ov, exp_opc);
      end
      if (out_valid && !seen) begin first_pc = out_pc; seen = 1'b1; end
      advance();
    end
    n_cmp++; if (first_pc !== 32'h0) begin n_fail++; $display("FAIL midrst_first_out got %h want 00000000", first_pc); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no completion within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_inflight();
    test_collide();
    test_back_to_back();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
